// File: rtl/cam_fill_ctrl_if.sv
// cam_fill_ctrl_if -- bundles the signals of the CAM fill controller.
//   Two lookup miss ports: reqN_valid/reqN_addr in, reqN_ready out.
//   Flush handshake: flush_req in, flush_done out.
//   Memory read: mem_req_* request handshake, mem_resp_* return.
//   CAM write/clear: cam_we, cam_write_addr, cam_write_data, cam_invalidate.
//   Status: fill_done, fill_port, fill_err, busy.
// slave = the controller, master = the surrounding logic.
interface cam_fill_ctrl_if;
   logic        req0_valid;
   logic [18:0] req0_addr;
   logic        req0_ready;
   logic        req1_valid;
   logic [18:0] req1_addr;
   logic        req1_ready;
   logic        flush_req;
   logic        flush_done;
   logic        mem_req_valid;
   logic [18:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        cam_we;
   logic [19:0] cam_write_addr;
   logic [31:0] cam_write_data;
   logic        cam_invalidate;
   logic        fill_done;
   logic        fill_port;
   logic        fill_err;
   logic        busy;

   modport slave (
      input  req0_valid, req0_addr, req1_valid, req1_addr, flush_req,
             mem_req_ready, mem_resp_valid, mem_resp_data,
      output req0_ready, req1_ready, flush_done, mem_req_valid, mem_req_addr,
             cam_we, cam_write_addr, cam_write_data, cam_invalidate,
             fill_done, fill_port, fill_err, busy
   );

   modport master (
      output req0_valid, req0_addr, req1_valid, req1_addr, flush_req,
             mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req0_ready, req1_ready, flush_done, mem_req_valid, mem_req_addr,
             cam_we, cam_write_addr, cam_write_data, cam_invalidate,
             fill_done, fill_port, fill_err, busy
   );
endinterface

// File: rtl/cam_fill_ctrl.sv
// cam_fill_ctrl -- services CAM misses from two lookup ports.
//   A miss is granted round-robin, its line is read from memory and
//   written into one of two CAM ways (alternating victim). A flush clears
//   the CAM and resets the victim. A memory read that sees no response
//   within MEM_TIMEOUT cycles is aborted with a fill_err pulse.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - cam_fill_ctrl_if.slave (requests, memory, CAM, status)
module cam_fill_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   cam_fill_ctrl_if.slave  bus
);

   localparam logic [9:0] TMO = 10'(MEM_TIMEOUT);

   typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, WRITE, FLUSH} state_t;

   state_t      state_q;
   logic        ptr_q;      // port preferred on a tie
   logic        victim_q;   // way the next fill writes
   logic        port_q;     // port id of the fill in flight
   logic [18:0] addr_q;     // captured miss address, drives mem_req_addr
   logic [9:0]  cnt_q;
   logic        mem_req_valid_q, cam_we_q, cam_inv_q, flush_done_q;
   logic        fill_done_q, fill_port_q, fill_err_q, busy_q;
   logic [19:0] cam_waddr_q;
   logic [31:0] cam_wdata_q; // doubles as the response capture register

   logic        gnt_d, idle_ok_d, rdy0_d, rdy1_d, tmo_d;
   logic [9:0]  cnt_d;

   // Grant: a lone valid port wins, a tie goes to the preferred port.
   always_comb begin
      idle_ok_d = (state_q == IDLE) && !bus.flush_req;
      gnt_d     = bus.req0_valid ? (bus.req1_valid ? ptr_q : 1'b0) : 1'b1;
      rdy0_d    = idle_ok_d && bus.req0_valid && !gnt_d;
      rdy1_d    = idle_ok_d && bus.req1_valid && gnt_d;
      cnt_d     = cnt_q + 10'd1;
      tmo_d     = (cnt_d == TMO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         ptr_q           <= 1'b0;
         victim_q        <= 1'b0;
         port_q          <= 1'b0;
         addr_q          <= '0;
         cnt_q           <= '0;
         mem_req_valid_q <= 1'b0;
         cam_we_q        <= 1'b0;
         cam_inv_q       <= 1'b0;
         flush_done_q    <= 1'b0;
         fill_done_q     <= 1'b0;
         fill_port_q     <= 1'b0;
         fill_err_q      <= 1'b0;
         busy_q          <= 1'b0;
         cam_waddr_q     <= '0;
         cam_wdata_q     <= '0;
      end else begin
         // single-cycle strobes default low
         cam_we_q     <= 1'b0;
         cam_inv_q    <= 1'b0;
         flush_done_q <= 1'b0;
         fill_done_q  <= 1'b0;
         fill_port_q  <= 1'b0;
         fill_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.flush_req) begin
                  state_q      <= FLUSH;
                  busy_q       <= 1'b1;
                  cam_inv_q    <= 1'b1;
                  flush_done_q <= 1'b1;
               end else if (rdy0_d || rdy1_d) begin
                  state_q         <= MEM_REQ;
                  busy_q          <= 1'b1;
                  addr_q          <= gnt_d ? bus.req1_addr : bus.req0_addr;
                  port_q          <= gnt_d;
                  ptr_q           <= ~gnt_d;
                  mem_req_valid_q <= 1'b1;
               end
            end
            MEM_REQ: begin
               if (bus.mem_req_ready) begin
                  state_q         <= MEM_WAIT;
                  mem_req_valid_q <= 1'b0;
                  cnt_q           <= '0;
               end
            end
            MEM_WAIT: begin
               // response checked first so it wins over a same-cycle timeout
               if (bus.mem_resp_valid) begin
                  state_q     <= WRITE;
                  cam_wdata_q <= bus.mem_resp_data;
                  cam_waddr_q <= {victim_q, addr_q};
                  cam_we_q    <= 1'b1;
                  fill_done_q <= 1'b1;
                  fill_port_q <= port_q;
               end else if (tmo_d) begin
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  fill_err_q <= 1'b1;
                  cnt_q      <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            WRITE: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               victim_q <= ~victim_q;
            end
            FLUSH: begin
               state_q  <= IDLE;
               busy_q   <= 1'b0;
               victim_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req0_ready     = rdy0_d;
   assign bus.req1_ready     = rdy1_d;
   assign bus.flush_done     = flush_done_q;
   assign bus.mem_req_valid  = mem_req_valid_q;
   assign bus.mem_req_addr   = addr_q;
   assign bus.cam_we         = cam_we_q;
   assign bus.cam_write_addr = cam_waddr_q;
   assign bus.cam_write_data = cam_wdata_q;
   assign bus.cam_invalidate = cam_inv_q;
   assign bus.fill_done      = fill_done_q;
   assign bus.fill_port      = fill_port_q;
   assign bus.fill_err       = fill_err_q;
   assign bus.busy           = busy_q;

endmodule

// File: doc/cam_fill_ctrl.md
CAM_FILL_CTRL -- requirements
Module: cam_fill_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the number of MEM_WAIT cycles without a response before a fill is aborted (legal range 1..1023).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports req0_valid, input, 1, and req0_addr, input, 19: miss request from lookup port 1.
REQ-005 SHALL have port req0_ready, output, 1: req0 accepted this cycle.
REQ-006 SHALL have ports req1_valid, input, 1, req1_addr, input, 19, and req1_ready, output, 1: same meanings for lookup port 2.
REQ-007 SHALL have ports flush_req, input, 1, and flush_done, output, 1: cache invalidate request and its 1-cycle completion pulse.
REQ-008 SHALL have ports mem_req_valid, output, 1, mem_req_addr, output, 19, and mem_req_ready, input, 1: memory read request handshake.
REQ-009 SHALL have ports mem_resp_valid, input, 1, and mem_resp_data, input, 32: memory read return.
REQ-010 SHALL have ports cam_we, output, 1, cam_write_addr, output, 20, cam_write_data, output, 32, and cam_invalidate, output, 1: CAM write and clear controls.
REQ-011 SHALL have ports fill_done, output, 1, fill_port, output, 1, fill_err, output, 1, and busy, output, 1: completion status and busy status.

Function
REQ-012 SHALL implement the states IDLE, MEM_REQ, MEM_WAIT, WRITE and FLUSH; busy SHALL be 1 in every state except IDLE.
REQ-013 In IDLE, flush_req=1 SHALL have priority: the block enters FLUSH and both req*_ready stay 0.
REQ-014 In IDLE with no flush_req, a valid request SHALL be granted round-robin: with one valid port, that port is granted; with both valid, the port not granted last is granted.
REQ-015 The grant pointer SHALL reset so that port 0 wins the first tie.
REQ-016 req*_ready SHALL be combinational, 1 only for the granted port in IDLE; the valid&ready handshake SHALL capture the address and port id, then the block enters MEM_REQ.
REQ-017 In MEM_REQ, mem_req_valid SHALL be 1 with mem_req_addr held at the captured address until mem_req_ready=1; the block then enters MEM_WAIT.
REQ-018 In MEM_REQ, mem_resp_valid SHALL be ignored.
REQ-019 In MEM_WAIT, a 10-bit counter starting at 0 SHALL increment each cycle without a response.
REQ-020 In MEM_WAIT, mem_resp_valid=1 SHALL capture mem_resp_data and move the block to WRITE.
REQ-021 In MEM_WAIT, if the counter reaches MEM_TIMEOUT first, the block SHALL pulse fill_err for 1 cycle, perform no CAM write and return to IDLE.
REQ-022 If mem_resp_valid arrives in the same cycle the counter reaches MEM_TIMEOUT, the response SHALL win.
REQ-023 WRITE SHALL last exactly 1 cycle with cam_we=1, cam_write_addr={victim, addr[18:0]} and cam_write_data set to the captured data.
REQ-024 In the WRITE cycle, fill_done SHALL be 1 and fill_port SHALL be the granted port id; the block then returns to IDLE.
REQ-025 victim SHALL be a 1-bit way selector that toggles after each completed WRITE.
REQ-026 A timed-out fill SHALL NOT toggle victim.
REQ-027 FLUSH SHALL last exactly 1 cycle with cam_invalidate=1 and flush_done=1; it SHALL clear victim to 0, and the block then returns to IDLE.
REQ-028 flush_req arriving while busy SHALL be held off until IDLE; the requester holds it high.
REQ-029 The grant pointer SHALL update only on an accepted request.
REQ-030 Fill latency SHALL be: accept at cycle T, mem_req_valid at T+1, and with mem_req_ready at T+1 and the response at T+2, cam_we at T+3.
REQ-031 cam_we and cam_invalidate SHALL never be 1 in the same cycle.
REQ-032 Outside their defining states, all outputs SHALL be 0, except cam_write_addr, cam_write_data and mem_req_addr, which hold their last values.

Reset
REQ-033 While rst=1, the block SHALL be asynchronously forced to IDLE.
REQ-034 While rst=1, the grant pointer SHALL be 0, victim SHALL be 0 and the counter SHALL be 0.
REQ-035 While rst=1, every output SHALL be 0, including the address and data registers.
REQ-036 rst asserted mid-fill SHALL abandon the fill with no cam_we, no fill_done and no fill_err.

Verification
REQ-037 The bench SHALL cover: req0 addr=0x12345 alone, mem ready immediately, resp data=0xDEADBEEF one cycle later -> cam_we at T+3, cam_write_addr=0x12345 with bit 19=0, fill_done=1, fill_port=0.
REQ-038 The bench SHALL cover: req0 and req1 valid together, twice in succession -> first grant port 0, second grant port 1; second write has bit 19=1 (victim toggled).
REQ-039 The bench SHALL cover: MEM_TIMEOUT=4 with no response -> fill_err pulse 4 cycles after entering MEM_WAIT, no cam_we, next fill still uses way 0.
REQ-040 The bench SHALL cover: flush_req and req0_valid together in IDLE -> cam_invalidate=1 and flush_done=1 for 1 cycle, req0_ready=0; req0 accepted the following cycle.
REQ-041 The bench SHALL cover: rst pulsed during MEM_WAIT, followed by a late mem_resp_valid -> block stays IDLE, cam_we stays 0, all outputs 0.
REQ-042 The bench SHALL cover: mem_req_ready held 0 for 5 cycles -> mem_req_valid held with a stable address, mem_resp_valid ignored during those cycles.
